oam_dma_engine: RTL and testbench

- Sits between the CPU memory-input mux and cpu_memory on the CPU bus.
- Detects a CPU write to $4014 and stalls the CPU.
- Copies 256 bytes from CPU page {data,8'h00} to OAMDATA ($2004) as alternating read/write bus cycles.
- When idle, passes CPU address, read enable and write data straight through to cpu_memory.

---
 rtl/oam_dma_engine_pkg.sv | 12 +
 rtl/oam_dma_engine.sv | 85 ++++++++
 tb/tb_oam_dma_engine.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/oam_dma_engine_pkg.sv
// oam_dma_engine_pkg: shared CPU-bus state type and register addresses for OAM DMA
package oam_dma_engine_pkg;
    typedef enum logic [2:0] {
        DMA_IDLE  = 3'd0,
        DMA_HALT  = 3'd1,
        DMA_ALIGN = 3'd2,
        DMA_READ  = 3'd3,
        DMA_WRITE = 3'd4
    } dma_state_t;
    localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
    localparam logic [15:0] OAMDATA_ADDR = 16'h2004;
endpackage

// File: rtl/oam_dma_engine.sv
// oam_dma_engine: stalls the CPU on a $4014 write and copies one page to OAMDATA
module oam_dma_engine #(
    parameter logic [15:0] DMA_REG_ADDR = oam_dma_engine_pkg::OAMDMA_ADDR,
    parameter logic [15:0] OAMDATA_ADDR = oam_dma_engine_pkg::OAMDATA_ADDR,
    parameter logic [15:0] DUMMY_ADDR   = 16'h0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clock_en,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_r_en,
    input  logic [7:0]  cpu_w_data,
    input  logic [7:0]  mem_r_data,
    output logic [15:0] mem_addr,
    output logic        mem_r_en,
    output logic [7:0]  mem_w_data,
    output logic        cpu_stall,
    output logic        dma_active
);
    import oam_dma_engine_pkg::*;
    dma_state_t state;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] data_buf;
    logic       cycle_odd;
    logic       trigger;
    assign trigger = (cpu_addr == DMA_REG_ADDR) && !cpu_r_en;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= DMA_IDLE;
            page      <= 8'h00;
            idx       <= 8'h00;
            data_buf  <= 8'h00;
            cycle_odd <= 1'b0;
        end else if (clock_en) begin
            cycle_odd <= ~cycle_odd;
            case (state)
                DMA_IDLE: if (trigger) begin
                    page  <= cpu_w_data;
                    idx   <= 8'h00;
                    state <= DMA_HALT;
                end
                DMA_HALT:  state <= cycle_odd ? DMA_ALIGN : DMA_READ;
                DMA_ALIGN: state <= DMA_READ;
                DMA_READ:  state <= DMA_WRITE;
                DMA_WRITE: begin
                    data_buf <= mem_r_data;
                    if (idx == 8'hFF) state <= DMA_IDLE;
                    else begin
                        idx   <= idx + 8'd1;
                        state <= DMA_READ;
                    end
                end
                default: state <= DMA_IDLE;
            endcase
        end
    end
    // Read cycles park the last copied byte on the write bus instead of leaking CPU data
    always_comb begin
        mem_addr   = cpu_addr;
        mem_r_en   = cpu_r_en;
        mem_w_data = cpu_w_data;
        cpu_stall  = 1'b1;
        case (state)
            DMA_IDLE: cpu_stall = 1'b0;
            DMA_HALT, DMA_ALIGN: begin
                mem_addr   = DUMMY_ADDR;
                mem_r_en   = 1'b1;
                mem_w_data = data_buf;
            end
            DMA_READ: begin
                mem_addr   = {page, idx};
                mem_r_en   = 1'b1;
                mem_w_data = data_buf;
            end
            DMA_WRITE: begin
                mem_addr   = OAMDATA_ADDR;
                mem_r_en   = 1'b0;
                mem_w_data = mem_r_data;
            end
            default: cpu_stall = 1'b0;
        endcase
    end
    assign dma_active = cpu_stall;
endmodule

// File: tb/tb_oam_dma_engine.sv
// tb_oam_dma_engine: randomized scoreboard bench for the OAM DMA engine
module tb_oam_dma_engine;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        clock_en = 1'b1;
    logic [15:0] cpu_addr = 16'h0123;
    logic        cpu_r_en = 1'b0;
    logic [7:0]  cpu_w_data = 8'h5A;
    logic [7:0]  mem_r_data = 8'h00;
    logic [15:0] mem_addr;
    logic        mem_r_en;
    logic [7:0]  mem_w_data;
    logic        cpu_stall;
    logic        dma_active;

    typedef struct {
        logic [15:0] addr;
        logic        r_en;
        logic [7:0]  data;
    } bus_t;

    bus_t        q[$];
    logic [7:0]  ram [65536];
    int          total = 0;
    int          bad = 0;
    int          en_cnt;
    int          stall_cnt = 0;
    int          exp_stall = 0;

    oam_dma_engine dut (
        .clock(clock), .reset_n(reset_n), .clock_en(clock_en),
        .cpu_addr(cpu_addr), .cpu_r_en(cpu_r_en), .cpu_w_data(cpu_w_data),
        .mem_r_data(mem_r_data), .mem_addr(mem_addr), .mem_r_en(mem_r_en),
        .mem_w_data(mem_w_data), .cpu_stall(cpu_stall), .dma_active(dma_active)
    );

    always #5 clock = ~clock;

    // cpu_memory stand-in: registered read data, one CPU cycle latency
    always @(posedge clock) begin
        if (clock_en) begin
            if (mem_r_en) mem_r_data <= ram[mem_addr];
            else ram[mem_addr] <= mem_w_data;
        end
    end

    // CPU-cycle counter since reset; its low bit is the parity of the current cycle
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) en_cnt <= 0;
        else if (clock_en) en_cnt <= en_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n && clock_en) begin
            chk("active_eq_stall", 32'(dma_active), 32'(cpu_stall));
            if (q.size() > 0 && cpu_stall) begin
                bus_t e;
                e = q.pop_front();
                stall_cnt++;
                chk("dma_addr", 32'(mem_addr), 32'(e.addr));
                chk("dma_r_en", 32'(mem_r_en), 32'(e.r_en));
                if (!e.r_en) chk("dma_w_data", 32'(mem_w_data), 32'(e.data));
            end else if (q.size() == 0) begin
                chk("idle_stall", 32'(cpu_stall), 32'd0);
                chk("idle_pass", {7'd0, mem_addr, mem_r_en, mem_w_data},
                    {7'd0, cpu_addr, cpu_r_en, cpu_w_data});
            end else begin
                chk("stall_low_early", 32'(cpu_stall), 32'd1);
            end
        end
    end

    task automatic idle_cycle();
        cpu_addr = 16'($urandom);
        cpu_r_en = 1'b1;
        clock_en = 1'b1;
        @(posedge clock); #1;
    endtask

    // Reference: HALT, an ALIGN when the HALT cycle is odd, then 256 read/write pairs
    task automatic start(input logic [7:0] pg, input int odd_halt);
        for (int c = 0; c < 4 && ((en_cnt + 1) % 2) != odd_halt; c++) idle_cycle();
        cpu_addr = 16'h4014;
        cpu_r_en = 1'b0;
        cpu_w_data = pg;
        clock_en = 1'b1;
        @(posedge clock); #1;
        for (int d = 0; d < 1 + odd_halt; d++) q.push_back('{16'h0000, 1'b1, 8'h00});
        for (int i = 0; i < 256; i++) begin
            q.push_back('{{pg, 8'(i)}, 1'b1, 8'h00});
            q.push_back('{16'h2004, 1'b0, ram[{pg, 8'(i)}]});
        end
        exp_stall = 513 + odd_halt;
        stall_cnt = 0;
        cpu_addr = 16'($urandom);
        cpu_r_en = 1'b1;
    endtask

    task automatic drain(input bit rnd_en);
        for (int c = 0; c < 4000 && !(q.size() == 0 && !cpu_stall); c++) begin
            clock_en = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clock); #1;
        end
        clock_en = 1'b1;
        chk("drain_empty", 32'(q.size()), 32'd0);
        chk("stall_count", 32'(stall_cnt), 32'(exp_stall));
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            ram[16'h0200 + i] = 8'(i);
            ram[16'h0300 + i] = 8'($urandom);
        end
        #3;
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_active", 32'(dma_active), 32'd0);
        chk("rst_pass_addr", 32'(mem_addr), 32'h0123);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        #1;
        chk("idle_addr", 32'(mem_addr), 32'h0123);
        chk("idle_r_en", 32'(mem_r_en), 32'd0);
        chk("idle_w_data", 32'(mem_w_data), 32'h5A);
        chk("idle_nostall", 32'(cpu_stall), 32'd0);
        @(posedge clock); #1;

        start(8'h02, 0); drain(1'b0);
        repeat (2) idle_cycle();
        start(8'h02, 1); drain(1'b0);
        repeat (3) idle_cycle();
        start(8'h03, int'($urandom_range(0, 1))); drain(1'b1);
        repeat (2) idle_cycle();

        // abort while WRITE of idx 8'h40 is on the bus
        start(8'h02, int'($urandom_range(0, 1)));
        for (int c = 0; c < 2000 && q.size() != 383; c++) begin
            @(posedge clock); #1;
        end
        chk("abort_point", 32'(q.size()), 32'd383);
        chk("abort_write_addr", 32'(mem_addr), 32'h2004);
        reset_n = 1'b0;
        #1;
        chk("abort_stall", 32'(cpu_stall), 32'd0);
        chk("abort_active", 32'(dma_active), 32'd0);
        chk("abort_pass", 32'(mem_addr), 32'(cpu_addr));
        q.delete();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        cpu_addr = 16'h4000;
        cpu_r_en = 1'b1;
        #1;
        chk("post_rst_addr", 32'(mem_addr), 32'h4000);
        chk("post_rst_r_en", 32'(mem_r_en), 32'd1);
        @(posedge clock); #1;
        start(8'h02, int'($urandom_range(0, 1))); drain(1'b0);

        // non-triggering accesses
        cpu_addr = 16'h4014; cpu_r_en = 1'b1; cpu_w_data = 8'h02;
        @(posedge clock); #1;
        cpu_addr = 16'h4015; cpu_r_en = 1'b0;
        @(posedge clock); #1;
        repeat (3) idle_cycle();
        chk("no_dma_stall", 32'(cpu_stall), 32'd0);
        chk("no_dma_queue", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
